// File: rtl/streaming_fifo_param_if.sv
// Streaming handshake bundle for streaming_fifo_param: one AXI-Stream-style
// input channel (in0_V_*) and one output channel (out_V_*).
// Handshake: a word moves on a rising edge where TVALID and TREADY are both 1;
// the source keeps TDATA/TVALID stable until that edge, and TREADY never
// depends combinationally on TVALID.
interface streaming_fifo_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0_V_TDATA;
  logic             in0_V_TVALID;
  logic             in0_V_TREADY;
  logic [WIDTH-1:0] out_V_TDATA;
  logic             out_V_TVALID;
  logic             out_V_TREADY;

  // FIFO side: sinks the input channel, sources the output channel.
  modport slave (
    input  in0_V_TDATA, in0_V_TVALID, out_V_TREADY,
    output in0_V_TREADY, out_V_TDATA, out_V_TVALID
  );

  // Environment side: produces input words, consumes output words.
  modport master (
    output in0_V_TDATA, in0_V_TVALID, out_V_TREADY,
    input  in0_V_TREADY, out_V_TDATA, out_V_TVALID
  );
endinterface

// File: rtl/streaming_fifo_param.sv
// streaming_fifo_param: parametrised first-word-fall-through stream FIFO.
// Storage is a (DEPTH-1)-entry circular RAM plus one registered output word,
// so total capacity is DEPTH. Count, ready and the almost flags are all
// registered from count_next. err_sticky[0] latches a push attempt while full.
// Optional macro STREAMING_FIFO_HWM_EN adds a max_count high-water-mark port.
module streaming_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4096,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  streaming_fifo_param_if.slave        s,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [1:0]                   err_sticky
`ifdef STREAMING_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   max_count
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RD = DEPTH - 1;
  localparam int PW = (RD > 1) ? $clog2(RD) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] C_PLAST = PW'(RD - 1);

  logic [WIDTH-1:0] r_mem [RD];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_af, r_ae, r_err;

  logic             w_push, w_pop, w_load, w_bypass, w_ram_wr, w_ram_rd, w_ram_empty;
  logic [CW-1:0]    w_ram_cnt, w_count_next;

  // Pointer advance with explicit wrap at the last RAM entry (RAM depth need not be pow2).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_PLAST) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode and routing of the incoming word (RAM or straight to output).
  always_comb begin
    w_push       = s.in0_V_TVALID & r_in_ready;
    w_pop        = r_out_valid & s.out_V_TREADY;
    w_ram_cnt    = r_count - CW'(r_out_valid);
    w_ram_empty  = (w_ram_cnt == '0);
    w_load       = w_pop | ~r_out_valid;          // output slot is free this edge
    w_bypass     = w_push & w_load & w_ram_empty; // nothing queued ahead of it
    w_ram_wr     = w_push & ~w_bypass;
    w_ram_rd     = w_load & ~w_ram_empty;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  end

  // RAM write port; contents need no reset since count gates every read.
  always_ff @(posedge ap_clk) begin
    if (w_ram_wr) r_mem[r_wr_ptr] <= s.in0_V_TDATA;
  end

  // Pointers, output register, count, flags and sticky error.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      if (w_ram_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_ram_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_ram_rd) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[r_rd_ptr];
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_data  <= s.in0_V_TDATA;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;  // data holds its last value while empty
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < C_DEPTH);
      r_af       <= (w_count_next >= C_AF);
      r_ae       <= (w_count_next <= C_AE);
      if (s.in0_V_TVALID && !r_in_ready && (r_count == C_DEPTH)) r_err <= 1'b1;
    end
  end

`ifdef STREAMING_FIFO_HWM_EN
  logic [CW-1:0] r_max_count;
  // High-water mark of the fill level, for sizing DEPTH in profiling builds.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_max_count <= '0;
    else if (w_count_next > r_max_count) r_max_count <= w_count_next;
  end
  assign max_count = r_max_count;
`endif

  assign s.in0_V_TREADY = r_in_ready;
  assign s.out_V_TVALID = r_out_valid;
  assign s.out_V_TDATA  = r_out_data;
  assign count          = r_count;
  assign almost_full    = r_af;
  assign almost_empty   = r_ae;
  assign err_sticky     = {1'b0, r_err};
endmodule

// File: tb/tb_streaming_fifo_param.sv
// Bench for streaming_fifo_param: DUT A (DEPTH=4) for directed cases and
// DUT B (DEPTH=5, non-pow2) for randomized streaming. Each DUT is compared
// every cycle against a queue-based model of a FIFO of capacity DEPTH.
// Define STREAMING_FIFO_HWM_EN to also cover the max_count port.
module tb_streaming_fifo_param;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned depth_c [2] = '{4, 5};
  int unsigned af_c    [2] = '{2, 3};
  int unsigned ae_c    [2] = '{2, 2};

  logic       vin  [2];
  logic       ordy [2];
  logic [7:0] din  [2];

  wire        rdy_w [2];
  wire        ov_w  [2];
  wire [7:0]  od_w  [2];
  wire [2:0]  cnt_w [2];
  wire        af_w  [2];
  wire        ae_w  [2];
  wire [1:0]  err_w [2];
`ifdef STREAMING_FIFO_HWM_EN
  wire [2:0]  hwm_w [2];
`endif

  streaming_fifo_param_if #(.WIDTH(8)) if_a ();
  streaming_fifo_param_if #(.WIDTH(8)) if_b ();

  assign if_a.in0_V_TDATA  = din[0];
  assign if_a.in0_V_TVALID = vin[0];
  assign if_a.out_V_TREADY = ordy[0];
  assign rdy_w[0] = if_a.in0_V_TREADY;
  assign ov_w[0]  = if_a.out_V_TVALID;
  assign od_w[0]  = if_a.out_V_TDATA;
  assign if_b.in0_V_TDATA  = din[1];
  assign if_b.in0_V_TVALID = vin[1];
  assign if_b.out_V_TREADY = ordy[1];
  assign rdy_w[1] = if_b.in0_V_TREADY;
  assign ov_w[1]  = if_b.out_V_TVALID;
  assign od_w[1]  = if_b.out_V_TDATA;

  streaming_fifo_param #(.WIDTH(8), .DEPTH(4)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .s(if_a),
    .count(cnt_w[0]), .almost_full(af_w[0]), .almost_empty(ae_w[0]),
    .err_sticky(err_w[0])
`ifdef STREAMING_FIFO_HWM_EN
    , .max_count(hwm_w[0])
`endif
  );

  streaming_fifo_param #(.WIDTH(8), .DEPTH(5)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .s(if_b),
    .count(cnt_w[1]), .almost_full(af_w[1]), .almost_empty(ae_w[1]),
    .err_sticky(err_w[1])
`ifdef STREAMING_FIFO_HWM_EN
    , .max_count(hwm_w[1])
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q [2][$];
  logic [7:0] last_out [2];
  bit         m_err [2];
  bit         m_rdy [2];
  int         m_hwm [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        exp_q[i].delete();
        last_out[i] = 8'h00;
        m_err[i] = 1'b0;
        m_rdy[i] = 1'b0;
        m_hwm[i] = 0;
      end else begin
        bit push, pop;
        push = vin[i] && m_rdy[i];
        pop  = (exp_q[i].size() > 0) && ordy[i];
        if (vin[i] && !m_rdy[i] && exp_q[i].size() == int'(depth_c[i])) m_err[i] = 1'b1;
        if (pop)  last_out[i] = exp_q[i].pop_front();
        if (push) exp_q[i].push_back(din[i]);
        m_rdy[i] = exp_q[i].size() < int'(depth_c[i]);
        if (exp_q[i].size() > m_hwm[i]) m_hwm[i] = exp_q[i].size();
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int n;
      n = exp_q[i].size();
      check($sformatf("count%0d", i), 32'(cnt_w[i]), 32'(n));
      check($sformatf("tready%0d", i), 32'(rdy_w[i]), 32'(m_rdy[i]));
      check($sformatf("tvalid%0d", i), 32'(ov_w[i]), 32'(n > 0));
      check($sformatf("tdata%0d", i), 32'(od_w[i]), 32'((n > 0) ? exp_q[i][0] : last_out[i]));
      check($sformatf("afull%0d", i), 32'(af_w[i]), 32'(n >= int'(af_c[i])));
      check($sformatf("aempty%0d", i), 32'(ae_w[i]), 32'(n <= int'(ae_c[i])));
      check($sformatf("err%0d", i), 32'(err_w[i]), 32'({1'b0, m_err[i]}));
`ifdef STREAMING_FIFO_HWM_EN
      check($sformatf("hwm%0d", i), 32'(hwm_w[i]), 32'(m_hwm[i]));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic push_a(input logic [7:0] d);
    din[0] = d; vin[0] = 1'b1;
    step();
    vin[0] = 1'b0;
  endtask

  task automatic drain_a(input int n);
    ordy[0] = 1'b1;
    repeat (n) step();
    ordy[0] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int sent [2];
    logic [7:0] nxt;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b0; ordy[i] = 1'b0; din[i] = 8'h00;
      m_rdy[i] = 1'b0; m_err[i] = 1'b0; m_hwm[i] = 0; last_out[i] = 8'h00;
    end
    rst = 1'b1;
    step(); step();
    check("rst_aempty", 32'(ae_w[0]), 32'd1);
    check("rst_tready", 32'(rdy_w[0]), 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(rdy_w[0]), 32'd1);

    // FWFT latency 1
    push_a(8'h11);
    check("fwft_valid", 32'(ov_w[0]), 32'd1);
    check("fwft_data", 32'(od_w[0]), 32'h11);
    check("fwft_count", 32'(cnt_w[0]), 32'd1);
    drain_a(2);

    // fill to full, then overflow attempt
    for (int k = 1; k <= 4; k++) push_a(8'(k));
    check("full_count", 32'(cnt_w[0]), 32'd4);
    check("full_tready", 32'(rdy_w[0]), 32'd0);
    check("full_afull", 32'(af_w[0]), 32'd1);
    push_a(8'h05);
    check("ovf_err", 32'(err_w[0]), 32'd1);
    check("ovf_count", 32'(cnt_w[0]), 32'd4);

    // from full: continuous push and pop
    nxt = 8'h06;
    ordy[0] = 1'b1; vin[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bit pushed;
      din[0] = nxt;
      pushed = m_rdy[0];
      step();
      if (pushed) nxt++;
      check("steady_count", 32'(cnt_w[0] == 3'd3 || cnt_w[0] == 3'd4), 32'd1);
      check("steady_valid", 32'(ov_w[0]), 32'd1);
    end
    vin[0] = 1'b0;
    drain_a(6);

    // reset mid-stream with count=3
    for (int k = 0; k < 3; k++) push_a(8'h30 + 8'(k));
    check("pre_rst_count", 32'(cnt_w[0]), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_count", 32'(cnt_w[0]), 32'd0);
    check("rst_valid", 32'(ov_w[0]), 32'd0);
    check("rst_aempty2", 32'(ae_w[0]), 32'd1);
    check("rst_err", 32'(err_w[0]), 32'd0);
    step();
    push_a(8'hAA);
    check("post_rst_data", 32'(od_w[0]), 32'hAA);
    drain_a(2);

    // high-water mark: fill to 3, drain, reset
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int k = 0; k < 3; k++) push_a(8'h50 + 8'(k));
    drain_a(4);
`ifdef STREAMING_FIFO_HWM_EN
    check("hwm_three", 32'(hwm_w[0]), 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    check("hwm_reset", 32'(hwm_w[0]), 32'd0);
    step();
`endif

    // randomized streaming on both DUTs (B exercises wrap at DEPTH=5)
    sent[0] = 0; sent[1] = 0;
    cyc = 0;
    while ((sent[0] < 40 || sent[1] < 40 || exp_q[0].size() > 0 || exp_q[1].size() > 0)
           && cyc < 3000) begin
      bit pushed [2];
      for (int i = 0; i < 2; i++) begin
        vin[i]  = (sent[i] < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
        din[i]  = 8'($urandom_range(0, 255));
        ordy[i] = 1'($urandom_range(0, 3) != 0 || sent[i] >= 40);
        pushed[i] = vin[i] && m_rdy[i];
      end
      step();
      for (int i = 0; i < 2; i++) if (pushed[i]) sent[i]++;
      cyc++;
    end
    check("random_done", 32'(cyc < 3000), 32'd1);
    for (int i = 0; i < 2; i++) begin vin[i] = 1'b0; ordy[i] = 1'b0; end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
